// File: rtl/tile_sequencer.sv
// rtl/tile_sequencer.sv - per-tile weight-load / compute / write-back scheduler with phase watchdog
module tile_sequencer #(
    parameter int WIDTH_HEIGHT = 16,
    parameter int ADDR_W       = 8,
    parameter int TILE_W       = 8,
    parameter int TIMEOUT      = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [TILE_W-1:0] cmd_num_tiles,
    input  logic [ADDR_W-1:0] cmd_in_base,
    input  logic [ADDR_W-1:0] cmd_wt_base,
    input  logic [ADDR_W-1:0] cmd_out_base,
    output logic              wt_start,
    output logic              sys_start,
    output logic              wr_start,
    input  logic              wt_done,
    input  logic              sys_done,
    input  logic              wr_done,
    output logic [ADDR_W-1:0] in_addr,
    output logic [ADDR_W-1:0] wt_addr,
    output logic [ADDR_W-1:0] out_addr,
    output logic [TILE_W-1:0] tile_idx,
    output logic              busy,
    output logic              cmd_done,
    output logic              error
);

    localparam int CNT_W = $clog2(TIMEOUT) + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_W, S_COMPUTE, S_WRITE, S_DONE, S_ERR
    } state_t;

    state_t            state, state_nxt;
    logic [TILE_W-1:0] num_tiles, num_tiles_nxt, tile_idx_nxt;
    logic [ADDR_W-1:0] in_addr_nxt, wt_addr_nxt, out_addr_nxt;
    logic [CNT_W-1:0]  phase_cnt, phase_cnt_nxt;
    logic              wt_done_q, sys_done_q, wr_done_q;
    logic              wt_start_nxt, sys_start_nxt, wr_start_nxt;
    logic              wt_rise, sys_rise, wr_rise;
    logic              first_cycle, timeout_hit, in_phase_nxt;

    assign wt_rise     = wt_done  & ~wt_done_q;
    assign sys_rise    = sys_done & ~sys_done_q;
    assign wr_rise     = wr_done  & ~wr_done_q;
    // The start-pulse cycle of a phase is the one with a cleared counter.
    assign first_cycle = (phase_cnt == '0);
    assign timeout_hit = (phase_cnt == CNT_W'(TIMEOUT - 2));

    always_comb begin
        state_nxt     = state;
        num_tiles_nxt = num_tiles;
        tile_idx_nxt  = tile_idx;
        in_addr_nxt   = in_addr;
        wt_addr_nxt   = wt_addr;
        out_addr_nxt  = out_addr;
        wt_start_nxt  = 1'b0;
        sys_start_nxt = 1'b0;
        wr_start_nxt  = 1'b0;
        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    num_tiles_nxt = cmd_num_tiles;
                    tile_idx_nxt  = '0;
                    in_addr_nxt   = cmd_in_base;
                    wt_addr_nxt   = cmd_wt_base;
                    out_addr_nxt  = cmd_out_base;
                    if (cmd_num_tiles == '0) begin
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt    = S_LOAD_W;
                        wt_start_nxt = 1'b1;
                    end
                end
            end
            S_LOAD_W: begin
                if (wt_rise && !first_cycle) begin
                    state_nxt     = S_COMPUTE;
                    sys_start_nxt = 1'b1;
                end else if (timeout_hit) begin
                    state_nxt = S_ERR;
                end
            end
            S_COMPUTE: begin
                if (sys_rise && !first_cycle) begin
                    state_nxt    = S_WRITE;
                    wr_start_nxt = 1'b1;
                end else if (timeout_hit) begin
                    state_nxt = S_ERR;
                end
            end
            S_WRITE: begin
                if (wr_rise && !first_cycle) begin
                    if (tile_idx == num_tiles - TILE_W'(1)) begin
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt    = S_LOAD_W;
                        wt_start_nxt = 1'b1;
                        tile_idx_nxt = tile_idx + TILE_W'(1);
                        in_addr_nxt  = in_addr  + ADDR_W'(WIDTH_HEIGHT);
                        wt_addr_nxt  = wt_addr  + ADDR_W'(WIDTH_HEIGHT);
                        out_addr_nxt = out_addr + ADDR_W'(WIDTH_HEIGHT);
                    end
                end else if (timeout_hit) begin
                    state_nxt = S_ERR;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            S_ERR:   state_nxt = S_ERR;
            default: state_nxt = S_IDLE;
        endcase

        in_phase_nxt = (state_nxt == S_LOAD_W) || (state_nxt == S_COMPUTE) ||
                       (state_nxt == S_WRITE);
        // WRITE -> LOAD_W is a state change, so each tile's phases restart the count.
        if (!in_phase_nxt || state_nxt != state)
            phase_cnt_nxt = '0;
        else
            phase_cnt_nxt = phase_cnt + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            num_tiles  <= '0;
            tile_idx   <= '0;
            in_addr    <= '0;
            wt_addr    <= '0;
            out_addr   <= '0;
            phase_cnt  <= '0;
            wt_done_q  <= 1'b0;
            sys_done_q <= 1'b0;
            wr_done_q  <= 1'b0;
            wt_start   <= 1'b0;
            sys_start  <= 1'b0;
            wr_start   <= 1'b0;
            cmd_done   <= 1'b0;
            error      <= 1'b0;
            busy       <= 1'b0;
            cmd_ready  <= 1'b1;
        end else begin
            state      <= state_nxt;
            num_tiles  <= num_tiles_nxt;
            tile_idx   <= tile_idx_nxt;
            in_addr    <= in_addr_nxt;
            wt_addr    <= wt_addr_nxt;
            out_addr   <= out_addr_nxt;
            phase_cnt  <= phase_cnt_nxt;
            wt_done_q  <= wt_done;
            sys_done_q <= sys_done;
            wr_done_q  <= wr_done;
            wt_start   <= wt_start_nxt;
            sys_start  <= sys_start_nxt;
            wr_start   <= wr_start_nxt;
            cmd_done   <= (state_nxt == S_DONE);
            error      <= (state_nxt == S_ERR);
            busy       <= (state_nxt != S_IDLE) && (state_nxt != S_ERR);
            cmd_ready  <= (state_nxt == S_IDLE);
        end
    end

endmodule

// File: tb/tb_tile_sequencer.sv
// tb/tb_tile_sequencer.sv - event-queue model bench for tile_sequencer
module tb_tile_sequencer;

    localparam int WH = 16;
    localparam int TO = 8;

    logic       clk = 1'b0, reset = 1'b1, cmd_valid = 1'b0;
    logic [7:0] cmd_num_tiles = '0, cmd_in_base = '0, cmd_wt_base = '0, cmd_out_base = '0;
    logic       wt_done = 1'b0, sys_done = 1'b0, wr_done = 1'b0;
    logic       cmd_ready, wt_start, sys_start, wr_start, busy, cmd_done, error;
    logic [7:0] in_addr, wt_addr, out_addr, tile_idx;

    tile_sequencer #(.WIDTH_HEIGHT(WH), .ADDR_W(8), .TILE_W(8), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_num_tiles(cmd_num_tiles), .cmd_in_base(cmd_in_base),
        .cmd_wt_base(cmd_wt_base), .cmd_out_base(cmd_out_base),
        .wt_start(wt_start), .sys_start(sys_start), .wr_start(wr_start),
        .wt_done(wt_done), .sys_done(sys_done), .wr_done(wr_done),
        .in_addr(in_addr), .wt_addr(wt_addr), .out_addr(out_addr),
        .tile_idx(tile_idx), .busy(busy), .cmd_done(cmd_done), .error(error)
    );

    always #5 clk = ~clk;

    // kind: 0 weight start, 1 compute start, 2 write start, 3 command done
    typedef struct {
        int         kind;
        int         tile;
        logic [7:0] ia, wa, oa;
    } ev_t;

    ev_t        q[$];
    ev_t        e;
    int         cyc = 0, pending = -1, deadline = -1, clear_at = -1;
    bit         m_busy = 0, m_err = 0, ready_prev, rise;
    logic       pwt = 0, psys = 0, pwr = 0;
    int         n_checks = 0, n_fail = 0;
    int         cnt_wt = 0, cnt_sys = 0, cnt_wr = 0, cnt_done = 0;
    int         np, act_kind;
    logic [7:0] out_hist[$];
    logic [7:0] tile_hist[$];
    bit         sys_en = 1;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Model: expected pulse sequence is built at acceptance; each phase rise releases the next entry.
    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            q.delete();
            m_busy = 0; m_err = 0; pending = -1; deadline = -1; clear_at = -1;
            pwt = 0; psys = 0; pwr = 0;
        end else begin
            ready_prev = !m_busy && !m_err;
            if (clear_at == cyc) m_busy = 0;
            if (cmd_valid && ready_prev) begin
                for (int t = 0; t < int'(cmd_num_tiles); t++) begin
                    for (int k = 0; k < 3; k++) begin
                        e.kind = k; e.tile = t;
                        e.ia = cmd_in_base  + 8'(WH * t);
                        e.wa = cmd_wt_base  + 8'(WH * t);
                        e.oa = cmd_out_base + 8'(WH * t);
                        q.push_back(e);
                    end
                end
                e.kind = 3; e.tile = 0; e.ia = 0; e.wa = 0; e.oa = 0;
                q.push_back(e);
                m_busy = 1;
                pending = cyc;
            end
            rise = 0;
            if (q.size() > 0 && pending < 0) begin
                if (wt_done && !pwt && q[0].kind == 1) rise = 1;
                if (sys_done && !psys && q[0].kind == 2) rise = 1;
                if (wr_done && !pwr && (q[0].kind == 0 || q[0].kind == 3)) rise = 1;
            end
            if (rise) begin
                pending = cyc;
                deadline = -1;
            end
            pwt = wt_done; psys = sys_done; pwr = wr_done;
            if (deadline == cyc) begin
                m_err = 1; m_busy = 0; q.delete(); pending = -1; deadline = -1;
            end
        end
    end

    always @(negedge clk) begin
        check("error", error, m_err);
        check("busy", busy, m_busy);
        check("cmd_ready", cmd_ready, !m_busy && !m_err);
        np = int'(wt_start) + int'(sys_start) + int'(wr_start) + int'(cmd_done);
        cnt_wt += int'(wt_start); cnt_sys += int'(sys_start);
        cnt_wr += int'(wr_start); cnt_done += int'(cmd_done);
        if (wt_start) begin
            out_hist.push_back(out_addr);
            tile_hist.push_back(tile_idx);
        end
        if (pending == cyc) begin
            check("pulse_count", np, 1);
            if (q.size() == 0) begin
                check("queue_nonempty", 0, 1);
            end else begin
                e = q.pop_front();
                act_kind = wt_start ? 0 : sys_start ? 1 : wr_start ? 2 : cmd_done ? 3 : 7;
                check("pulse_kind", act_kind, e.kind);
                if (e.kind < 3) begin
                    check("tile_idx", tile_idx, e.tile);
                    check("in_addr", in_addr, e.ia);
                    check("wt_addr", wt_addr, e.wa);
                    check("out_addr", out_addr, e.oa);
                    deadline = cyc + TO - 1;
                end else begin
                    clear_at = cyc + 1;
                end
            end
            pending = -1;
        end else begin
            check("spurious_pulse", np, 0);
        end
    end

    // Phase responders: done drops 2 cycles after start and rises 5 cycles after start.
    initial forever begin
        @(negedge clk);
        if (wt_start) begin
            repeat (2) @(posedge clk); #1 wt_done = 0;
            repeat (3) @(posedge clk); #1 wt_done = 1;
        end
    end
    initial forever begin
        @(negedge clk);
        if (sys_start) begin
            repeat (2) @(posedge clk); #1 sys_done = 0;
            repeat (3) @(posedge clk); #1 sys_done = sys_en;
        end
    end
    initial forever begin
        @(negedge clk);
        if (wr_start) begin
            repeat (2) @(posedge clk); #1 wr_done = 0;
            repeat (3) @(posedge clk); #1 wr_done = 1;
        end
    end

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(int n, logic [7:0] ib, logic [7:0] wb, logic [7:0] ob);
        tick(1);
        cmd_num_tiles = 8'(n); cmd_in_base = ib; cmd_wt_base = wb; cmd_out_base = ob;
        cmd_valid = 1;
        tick(1);
        cmd_valid = 0;
        cmd_num_tiles = 8'hAA; cmd_in_base = 8'hAA; cmd_wt_base = 8'hAA; cmd_out_base = 8'hAA;
    endtask

    task automatic wait_done(int budget, string name);
        int d0 = cnt_done;
        int k = 0;
        while (cnt_done == d0 && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        check(name, cnt_done > d0, 1);
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, "_ready"}, cmd_ready, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_error"}, error, 0);
        check({tag, "_tile"}, tile_idx, 0);
        check({tag, "_addrs"}, {in_addr, wt_addr, out_addr}, 24'h0);
        check({tag, "_pulses"}, {wt_start, sys_start, wr_start, cmd_done}, 4'h0);
    endtask

    int c0, c1, c2, c3, s_cyc, e_cyc, k;

    initial begin
        tick(3);
        reset = 0;
        @(negedge clk); #1;
        check_reset_outputs("rst");

        // single tile
        c0 = cnt_wt; c1 = cnt_sys; c2 = cnt_wr;
        send(1, 8'h10, 8'h20, 8'h30);
        wait_done(80, "t1_done_seen");
        check("t1_pulses", {8'(cnt_wt - c0), 8'(cnt_sys - c1), 8'(cnt_wr - c2)}, 24'h010101);
        check("t1_addrs", {in_addr, wt_addr, out_addr}, 24'h102030);

        // three tiles with output-address wrap
        out_hist.delete(); tile_hist.delete();
        c0 = cnt_wt + cnt_sys + cnt_wr; c3 = cnt_done;
        send(3, 8'h00, 8'h40, 8'hF0);
        wait_done(200, "t3_done_seen");
        check("t3_starts", cnt_wt + cnt_sys + cnt_wr - c0, 9);
        check("t3_cmd_done", cnt_done - c3, 1);
        check("t3_hist_len", out_hist.size(), 3);
        if (out_hist.size() == 3) begin
            check("t3_out_seq", {out_hist[0], out_hist[1], out_hist[2]}, 24'hF00010);
            check("t3_tile_seq", {tile_hist[0], tile_hist[1], tile_hist[2]}, 24'h000102);
        end

        // wr_done stays high from the previous command
        check("stale_level", wr_done, 1);
        c2 = cnt_wr;
        send(2, 8'h01, 8'h02, 8'h03);
        wait_done(150, "stale_done_seen");
        check("stale_wr_starts", cnt_wr - c2, 2);

        // zero-tile command
        c0 = cnt_wt + cnt_sys + cnt_wr;
        send(0, 8'h55, 8'h66, 8'h77);
        @(negedge clk); #1;
        check("zero_done_n1", {cmd_done, cmd_ready}, 2'b10);
        @(negedge clk); #1;
        check("zero_ready_n2", {cmd_done, cmd_ready}, 2'b01);
        check("zero_no_starts", cnt_wt + cnt_sys + cnt_wr - c0, 0);

        // reset during tile 1 write phase
        c2 = cnt_wr;
        send(2, 8'h80, 8'h90, 8'hA0);
        k = 0;
        while (cnt_wr < c2 + 2 && k < 100) begin
            @(negedge clk); #1;
            k++;
        end
        check("mid_reached_wr1", cnt_wr - c2, 2);
        check("mid_tile1", tile_idx, 1);
        tick(1);
        reset = 1;
        tick(1);
        reset = 0;
        @(negedge clk); #1;
        check_reset_outputs("mid_rst");
        tick(8);
        send(1, 8'h04, 8'h05, 8'h06);
        wait_done(80, "post_rst_done_seen");

        // watchdog on a compute phase that never completes
        sys_en = 0;
        send(1, 8'h00, 8'h00, 8'h00);
        s_cyc = -1; e_cyc = -1; k = 0;
        while (s_cyc < 0 && k < 50) begin
            @(negedge clk);
            if (sys_start) s_cyc = cyc;
            k++;
        end
        k = 0;
        while (e_cyc < 0 && k < 30) begin
            @(negedge clk);
            if (error) e_cyc = cyc;
            k++;
        end
        check("wd_seen", (s_cyc >= 0) && (e_cyc >= 0), 1);
        check("wd_latency", e_cyc - s_cyc, TO - 1);
        #1;
        check("wd_outputs", {error, busy, cmd_ready}, 3'b100);
        c0 = cnt_wt + cnt_done;
        send(1, 8'h11, 8'h22, 8'h33);
        tick(10);
        check("wd_ignored", cnt_wt + cnt_done - c0, 0);
        check("wd_sticky", error, 1);
        reset = 1;
        sys_en = 1;
        tick(2);
        reset = 0;
        @(negedge clk); #1;
        check_reset_outputs("wd_rst");
        tick(8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
